// File: rtl/noc_pkg.sv
// Shared NoC definitions: injection FSM encoding and packet field geometry.
// Packet layout is {row, col, data} with data in the LSBs.
package noc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_CHECK   = 2'd2,
      ST_BACKOFF = 2'd3
   } inj_state_e;

   function automatic int pckt_width(input int data_w, input int rows, input int cols);
      return data_w + $clog2(rows) + $clog2(cols);
   endfunction

   function automatic int col_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int row_lsb(input int data_w, input int cols);
      return data_w + $clog2(cols);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found searching
// upward from ptr_i+1 (mod REQ_N) wins.
module rr_arbiter #(
   parameter  int REQ_N = 4,
   localparam int ID_W  = $clog2(REQ_N)
) (
   input  logic [REQ_N-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [REQ_N-1:0] grant_o,
   output logic [ID_W-1:0]  idx_o,
   output logic             any_o
);

   int k;

   // NOTE: every output gets a default before the search loop so no path leaves
   // a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      k       = 0;
      // Walk from the farthest offset down so the nearest candidate is written last.
      for (int i = REQ_N; i >= 1; i--) begin
         k = (int'(ptr_i) + i) % REQ_N;
         if (req_i[k]) begin
            grant_o    = '0;
            grant_o[k] = 1'b1;
            idx_o      = ID_W'(k);
            any_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Injection-side scheduler: round-robin shares one node injection port among
// REQ_N requesters, stalls on full, retransmits after backoff on overflow.
module noc_inject_arbiter
   import noc_pkg::*;
#(
   parameter  int REQ_N       = 4,
   parameter  int ROW_N       = 3,
   parameter  int COL_M       = 3,
   parameter  int PCKT_DATA_W = 8,
   parameter  int BACKOFF_CYC = 4,
   parameter  int MAX_RETRY   = 3,
   localparam int RA_W        = $clog2(ROW_N),
   localparam int CA_W        = $clog2(COL_M),
   localparam int PCKT_W      = pckt_width(PCKT_DATA_W, ROW_N, COL_M),
   localparam int ID_W        = $clog2(REQ_N)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [REQ_N-1:0]             req_valid_i,
   output logic [REQ_N-1:0]             req_ready_o,
   input  logic [REQ_N*RA_W-1:0]        req_row_i,
   input  logic [REQ_N*CA_W-1:0]        req_col_i,
   input  logic [REQ_N*PCKT_DATA_W-1:0] req_data_i,
   output logic [PCKT_W-1:0]            pckt_o,
   output logic                         wren_o,
   input  logic                         full_i,
   input  logic                         ovrflw_i,
   output logic                         busy_o,
   output logic                         sent_o,
   output logic                         drop_o,
   output logic [ID_W-1:0]              grant_id_o
);

   localparam int RT_W = $clog2(MAX_RETRY + 1);
   localparam int BO_W = $clog2(BACKOFF_CYC + 1);
   localparam logic [RT_W-1:0] RETRY_MAX = RT_W'(MAX_RETRY);
   localparam logic [RT_W-1:0] RETRY_ONE = RT_W'(1);
   localparam logic [BO_W-1:0] BO_LOAD   = BO_W'(BACKOFF_CYC);
   localparam logic [BO_W-1:0] BO_ONE    = BO_W'(1);

   inj_state_e        state_q, state_d;
   logic [ID_W-1:0]   ptr_q;
   logic [REQ_N-1:0]  grant_vec;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_any;
   logic              grant_fire;
   logic              retry_fire;
   logic [RT_W-1:0]   retry_q;
   logic [BO_W-1:0]   backoff_q;
   logic [PCKT_W-1:0] pckt_q;
   logic [ID_W-1:0]   grant_id_q;

   rr_arbiter #(.REQ_N(REQ_N)) u_rr_arbiter (
      .req_i   (req_valid_i),
      .ptr_i   (ptr_q),
      .grant_o (grant_vec),
      .idx_o   (grant_idx),
      .any_o   (grant_any)
   );

   always_comb begin
      state_d     = state_q;
      req_ready_o = '0;
      wren_o      = 1'b0;
      sent_o      = 1'b0;
      drop_o      = 1'b0;
      grant_fire  = 1'b0;
      retry_fire  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               req_ready_o = grant_vec;
               grant_fire  = 1'b1;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            wren_o = !full_i;
            if (!full_i) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (!ovrflw_i) begin
               sent_o  = 1'b1;
               state_d = ST_IDLE;
            end else if (retry_q < RETRY_MAX) begin
               retry_fire = 1'b1;
               state_d    = ST_BACKOFF;
            end else begin
               drop_o  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_BACKOFF: begin
            if (backoff_q == BO_ONE) state_d = ST_SEND;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         ptr_q      <= ID_W'(REQ_N - 1);
         retry_q    <= '0;
         backoff_q  <= '0;
         pckt_q     <= '0;
         grant_id_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant_fire) begin
            pckt_q     <= {req_row_i[grant_idx*RA_W +: RA_W],
                           req_col_i[grant_idx*CA_W +: CA_W],
                           req_data_i[grant_idx*PCKT_DATA_W +: PCKT_DATA_W]};
            grant_id_q <= grant_idx;
            ptr_q      <= grant_idx;
            retry_q    <= '0;
         end
         if (retry_fire) begin
            retry_q   <= retry_q + RETRY_ONE;
            backoff_q <= BO_LOAD;
         end else if (state_q == ST_BACKOFF) begin
            backoff_q <= backoff_q - BO_ONE;
         end
      end
   end

   assign pckt_o     = pckt_q;
   assign grant_id_o = grant_id_q;
   assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed self-checking bench for noc_inject_arbiter: grant order, packet
// build, full stall, overflow retransmit, drop, and asynchronous reset.
module tb_noc_inject_arbiter;

   localparam int REQ_N = 4;
   localparam int ROW_N = 3;
   localparam int COL_M = 3;
   localparam int DW    = 8;
   localparam int BO    = 4;
   localparam int MR    = 3;
   localparam int RA_W  = 2;
   localparam int CA_W  = 2;
   localparam int PW    = DW + RA_W + CA_W;
   localparam int ID_W  = 2;

   logic                    clk;
   logic                    rst_n;
   logic [REQ_N-1:0]        valid;
   logic [REQ_N-1:0]        ready;
   logic [REQ_N*RA_W-1:0]   row;
   logic [REQ_N*CA_W-1:0]   col;
   logic [REQ_N*DW-1:0]     data;
   logic [PW-1:0]           pckt;
   logic                    wren;
   logic                    full;
   logic                    ovr;
   logic                    busy;
   logic                    sent;
   logic                    drop;
   logic [ID_W-1:0]         gid;

   logic [RA_W-1:0] row_a  [REQ_N];
   logic [CA_W-1:0] col_a  [REQ_N];
   logic [DW-1:0]   data_a [REQ_N];

   int n_cmp = 0;
   int n_err = 0;
   int gap, writes, drops, sents, cyc;

   noc_inject_arbiter #(
      .REQ_N(REQ_N), .ROW_N(ROW_N), .COL_M(COL_M), .PCKT_DATA_W(DW),
      .BACKOFF_CYC(BO), .MAX_RETRY(MR)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (valid),
      .req_ready_o (ready),
      .req_row_i   (row),
      .req_col_i   (col),
      .req_data_i  (data),
      .pckt_o      (pckt),
      .wren_o      (wren),
      .full_i      (full),
      .ovrflw_i    (ovr),
      .busy_o      (busy),
      .sent_o      (sent),
      .drop_o      (drop),
      .grant_id_o  (gid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [PW-1:0] exp_pkt(input int k);
      return {row_a[k], col_a[k], data_a[k]};
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pckt"},  32'(pckt),  32'h0);
      chk({tag, "_wren"},  32'(wren),  32'h0);
      chk({tag, "_ready"}, 32'(ready), 32'h0);
      chk({tag, "_busy"},  32'(busy),  32'h0);
      chk({tag, "_sent"},  32'(sent),  32'h0);
      chk({tag, "_drop"},  32'(drop),  32'h0);
      chk({tag, "_gid"},   32'(gid),   32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      row_a[0] = 2'd2; col_a[0] = 2'd1; data_a[0] = 8'hA5;
      row_a[1] = 2'd1; col_a[1] = 2'd2; data_a[1] = 8'h3C;
      row_a[2] = 2'd0; col_a[2] = 2'd0; data_a[2] = 8'h5A;
      row_a[3] = 2'd2; col_a[3] = 2'd2; data_a[3] = 8'hF0;
      for (int k = 0; k < REQ_N; k++) begin
         row[k*RA_W +: RA_W] = row_a[k];
         col[k*CA_W +: CA_W] = col_a[k];
         data[k*DW +: DW]    = data_a[k];
      end
      rst_n = 1'b0; valid = '0; full = 1'b0; ovr = 1'b0;
      tick(); tick();
      #1;
      chk_reset_vals("reset");
      rst_n = 1'b1;
      tick();

      // Single packet, best-case latency
      valid = 4'b0001;
      #1;
      chk("t1_ready", 32'(ready), 32'h1);
      chk("t1_busy_idle", 32'(busy), 32'h0);
      tick();
      valid = '0;
      #1;
      chk("t1_pckt", 32'(pckt), 32'h9A5);
      chk("t1_wren", 32'(wren), 32'h1);
      chk("t1_gid", 32'(gid), 32'h0);
      chk("t1_ready_send", 32'(ready), 32'h0);
      tick(); #1;
      chk("t1_sent", 32'(sent), 32'h1);
      chk("t1_wren_check", 32'(wren), 32'h0);
      chk("t1_drop", 32'(drop), 32'h0);
      tick(); #1;
      chk("t1_sent_gone", 32'(sent), 32'h0);
      chk("t1_busy_end", 32'(busy), 32'h0);

      // Reset pulse so requester 0 wins first again
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();

      // Round robin with all four valid: 0,1,2,3,0 every 3 cycles
      valid = '1;
      for (int n = 0; n < 5; n++) begin
         #1;
         chk($sformatf("rr%0d_ready", n), 32'(ready), 32'(1 << (n % 4)));
         tick(); #1;
         chk($sformatf("rr%0d_gid", n), 32'(gid), 32'(n % 4));
         chk($sformatf("rr%0d_pckt", n), 32'(pckt), 32'(exp_pkt(n % 4)));
         chk($sformatf("rr%0d_wren", n), 32'(wren), 32'h1);
         tick();
         if (n == 4) valid = '0;
         #1;
         chk($sformatf("rr%0d_sent", n), 32'(sent), 32'h1);
         tick();
      end

      // Full stall: five blocked SEND cycles, then a single write
      valid = 4'b0100;
      full  = 1'b1;
      #1;
      chk("full_ready", 32'(ready), 32'h4);
      tick();
      valid = '0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("full_hold%0d_wren", i), 32'(wren), 32'h0);
         chk($sformatf("full_hold%0d_sent", i), 32'(sent), 32'h0);
         tick();
      end
      full = 1'b0;
      #1;
      chk("full_release_wren", 32'(wren), 32'h1);
      chk("full_pckt", 32'(pckt), 32'(exp_pkt(2)));
      tick(); #1;
      chk("full_sent", 32'(sent), 32'h1);
      chk("full_wren_after", 32'(wren), 32'h0);
      tick();

      // One overflow: retransmit BO+2 cycles after the first write
      valid = 4'b1001;
      #1;
      chk("ovr1_ready", 32'(ready), 32'h8);
      tick();
      valid = '0;
      #1;
      chk("ovr1_first_wren", 32'(wren), 32'h1);
      tick();
      ovr = 1'b1;
      #1;
      chk("ovr1_check_sent", 32'(sent), 32'h0);
      chk("ovr1_check_drop", 32'(drop), 32'h0);
      tick();
      ovr = 1'b0;
      gap = 2;
      #1;
      while (wren !== 1'b1 && gap < 40) begin
         tick(); #1;
         gap++;
      end
      chk("ovr1_retx_gap", 32'(gap), 32'(BO + 2));
      chk("ovr1_retx_pckt", 32'(pckt), 32'(exp_pkt(3)));
      tick(); #1;
      chk("ovr1_sent", 32'(sent), 32'h1);
      tick();

      // Overflow on every CHECK: MR+1 writes, one drop, no sent
      valid = 4'b0010;
      ovr   = 1'b1;
      #1;
      chk("drop_ready", 32'(ready), 32'h2);
      tick();
      valid = '0;
      writes = 0; drops = 0; sents = 0; cyc = 0;
      #1;
      while (busy === 1'b1 && cyc < 200) begin
         writes += int'(wren);
         drops  += int'(drop);
         sents  += int'(sent);
         tick(); #1;
         cyc++;
      end
      chk("drop_writes", 32'(writes), 32'(MR + 1));
      chk("drop_pulses", 32'(drops), 32'h1);
      chk("drop_sents", 32'(sents), 32'h0);
      chk("drop_busy_cycles", 32'(cyc), 32'((MR + 1) * 2 + MR * BO));
      ovr   = 1'b0;
      valid = '1;
      #1;
      chk("drop_next_ready", 32'(ready), 32'h4);
      tick();
      valid = '0;
      #1;
      chk("drop_next_gid", 32'(gid), 32'h2);
      tick(); #1;
      chk("drop_next_sent", 32'(sent), 32'h1);
      tick();

      // Asynchronous reset in BACKOFF
      valid = 4'b1000;
      ovr   = 1'b1;
      #1;
      chk("rst_ready", 32'(ready), 32'h8);
      tick();
      valid = '0;
      tick();
      tick();
      ovr = 1'b0;
      #1;
      chk("rst_in_backoff_busy", 32'(busy), 32'h1);
      chk("rst_in_backoff_gid", 32'(gid), 32'h3);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_async");
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk($sformatf("rst_hold%0d_sent", i), 32'(sent), 32'h0);
         chk($sformatf("rst_hold%0d_drop", i), 32'(drop), 32'h0);
      end
      rst_n = 1'b1;
      valid = '1;
      #1;
      chk("rst_after_ready", 32'(ready), 32'h1);
      tick();
      valid = '0;
      #1;
      chk("rst_after_gid", 32'(gid), 32'h0);
      chk("rst_after_pckt", 32'(pckt), 32'(exp_pkt(0)));
      tick(); tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
